// File: rtl/clk_div_pkg.sv
// ============================================================
// Module   : clk_div_pkg -- shared channel state, period clamp
// Revision : 1.0
// ============================================================
`default_nettype none

package clk_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MAX_CNT_W  = 32;

  // Periods below MIN_PERIOD cannot form a high and a low phase.
  function automatic logic [MAX_CNT_W-1:0] eff_period(input logic [MAX_CNT_W-1:0] p);
    return (p < MIN_PERIOD) ? MAX_CNT_W'(MIN_PERIOD) : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ============================================================
// Module   : clk_div_ch -- one divider channel, shadowed config
// Revision : 1.0
// ============================================================
`default_nettype none

module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned RST_PERIOD = 50_000_000,
  parameter int unsigned RST_HIGH   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] c_rst_period = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] c_rst_high   = CNT_W'(RST_HIGH);
  localparam logic [CNT_W-1:0] c_zero       = '0;
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  ch_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_sh_period, r_sh_high;
  logic [CNT_W-1:0] r_act_period, r_act_high;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out, r_tick, r_pending;

  logic [CNT_W-1:0] w_new_period, w_new_high;
  logic [CNT_W-1:0] w_act_period_nxt, w_act_high_nxt, w_cnt_nxt, w_cnt_inc;
  logic             w_clk_out_nxt, w_tick_nxt, w_pending_nxt, w_last;
  logic [MAX_CNT_W-1:0] w_eff;

  // A write in the same cycle as a load is seen by that load (write-through).
  assign w_new_period = wr ? wr_period : r_sh_period;
  assign w_new_high   = wr ? wr_high   : r_sh_high;

  assign w_eff     = eff_period(MAX_CNT_W'(r_act_period));
  assign w_last    = (MAX_CNT_W'(r_cnt) == (w_eff - MAX_CNT_W'(1)));
  assign w_cnt_inc = r_cnt + c_one;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_clk_out_nxt    = r_clk_out;
    w_tick_nxt       = 1'b0;
    w_act_period_nxt = r_act_period;
    w_act_high_nxt   = r_act_high;
    w_pending_nxt    = r_pending;
    case (r_state)
      IDLE: begin
        w_cnt_nxt        = c_zero;
        w_clk_out_nxt    = 1'b0;
        w_act_period_nxt = w_new_period;
        w_act_high_nxt   = w_new_high;
        w_pending_nxt    = 1'b0;
        if (en) begin
          w_state_nxt   = RUN;
          w_tick_nxt    = 1'b1;
          w_clk_out_nxt = (w_new_high != c_zero);
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = c_zero;
          w_clk_out_nxt = 1'b0;
          w_pending_nxt = r_pending | wr;
        end else if (w_last) begin
          w_cnt_nxt        = c_zero;
          w_tick_nxt       = 1'b1;
          w_act_period_nxt = w_new_period;
          w_act_high_nxt   = w_new_high;
          w_clk_out_nxt    = (w_new_high != c_zero);
          w_pending_nxt    = 1'b0;
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_clk_out_nxt = (w_cnt_inc < r_act_high);
          w_pending_nxt = r_pending | wr;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= c_zero;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_pending    <= 1'b0;
      r_sh_period  <= c_rst_period;
      r_sh_high    <= c_rst_high;
      r_act_period <= c_rst_period;
      r_act_high   <= c_rst_high;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_tick       <= w_tick_nxt;
      r_pending    <= w_pending_nxt;
      r_sh_period  <= w_new_period;
      r_sh_high    <= w_new_high;
      r_act_period <= w_act_period_nxt;
      r_act_high   <= w_act_high_nxt;
    end
  end

  assign clk_out     = r_clk_out;
  assign tick        = r_tick;
  assign cfg_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/multi_clk_div.sv
// ============================================================
// Module   : multi_clk_div -- N_CH independent clock dividers
// Revision : 1.0
// ============================================================
`default_nettype none

module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned RST_PERIOD = 50_000_000,
  parameter int unsigned RST_HIGH   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  cfg_pending
);

  logic [N_CH-1:0] w_wr;

  // Indices at or above N_CH match no channel, so such writes fall away.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_wr[i] = cfg_wr && (cfg_ch == 4'(i));

    clk_div_ch #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_HIGH   (RST_HIGH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (en[i]),
      .wr          (w_wr[i]),
      .wr_period   (cfg_period),
      .wr_high     (cfg_high),
      .clk_out     (clk_out[i]),
      .tick        (tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_clk_div.sv
// Bench for multi_clk_div: phase-based channel model plus directed literal checks.
`default_nettype none

module tb_multi_clk_div;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int RST_P = 12;
  localparam int RST_H = 5;

  logic             clk, reset, cfg_wr;
  logic [N_CH-1:0]  en, clk_out, tick, cfg_pending;
  logic [3:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period, cfg_high;

  multi_clk_div #(
    .N_CH(N_CH), .CNT_W(CNT_W), .RST_PERIOD(RST_P), .RST_HIGH(RST_H)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: each channel is a running flag plus its position inside the current period.
  bit m_run[N_CH];
  bit m_pend[N_CH];
  int m_pos[N_CH], m_ap[N_CH], m_ah[N_CH], m_sp[N_CH], m_sh[N_CH];

  function automatic int eff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic bit is_wr(input int c);
    return cfg_wr && (int'(cfg_ch) == c);
  endfunction

  function automatic int nxt_p(input int c);
    return is_wr(c) ? int'(cfg_period) : m_sp[c];
  endfunction

  function automatic int nxt_h(input int c);
    return is_wr(c) ? int'(cfg_high) : m_sh[c];
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset) begin
        m_run[c] <= 1'b0; m_pos[c] <= 0; m_pend[c] <= 1'b0;
        m_sp[c] <= RST_P; m_sh[c] <= RST_H; m_ap[c] <= RST_P; m_ah[c] <= RST_H;
      end else begin
        m_sp[c] <= nxt_p(c);
        m_sh[c] <= nxt_h(c);
        if (!m_run[c]) begin
          m_ap[c] <= nxt_p(c); m_ah[c] <= nxt_h(c); m_pend[c] <= 1'b0; m_pos[c] <= 0;
          if (en[c]) m_run[c] <= 1'b1;
        end else if (!en[c]) begin
          m_run[c] <= 1'b0; m_pos[c] <= 0; m_pend[c] <= m_pend[c] | is_wr(c);
        end else if (m_pos[c] == eff(m_ap[c]) - 1) begin
          m_pos[c] <= 0; m_ap[c] <= nxt_p(c); m_ah[c] <= nxt_h(c); m_pend[c] <= 1'b0;
        end else begin
          m_pos[c] <= m_pos[c] + 1; m_pend[c] <= m_pend[c] | is_wr(c);
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [N_CH-1:0] e_clk, e_tick, e_pend;
    if (chk_on) begin
      for (int c = 0; c < N_CH; c++) begin
        e_clk[c]  = m_run[c] && (m_pos[c] < m_ah[c]);
        e_tick[c] = m_run[c] && (m_pos[c] == 0);
        e_pend[c] = m_pend[c];
      end
      chk("model_clk_out", int'(clk_out), int'(e_clk));
      chk("model_tick", int'(tick), int'(e_tick));
      chk("model_cfg_pending", int'(cfg_pending), int'(e_pend));
    end
  end

  task automatic wr_cfg(input int c, input int p, input int h);
    cfg_wr = 1'b1; cfg_ch = 4'(c); cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  int ntick, nhigh;
  int t_arr[24], p_arr[24];
  int cnt4[N_CH];

  initial begin
    reset = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_pending", int'(cfg_pending), 0);
    reset = 1'b0;

    // ch0 P=10 H=3
    wr_cfg(0, 10, 3);
    en[0] = 1'b1;
    ntick = 0; nhigh = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0)  chk("t1_first_tick", int'(tick[0]), 1);
      if (i == 10) chk("t1_tick_at_10", int'(tick[0]), 1);
      ntick += int'(tick[0]); nhigh += int'(clk_out[0]);
    end
    chk("t1_tick_count", ntick, 3);
    chk("t1_high_count", nhigh, 9);
    en[0] = 1'b0;

    // ch1: P=6 running, write P=8 H=4 at cnt=2
    wr_cfg(1, 6, 3);
    en[1] = 1'b1;
    ntick = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      t_arr[i] = int'(tick[1]); p_arr[i] = int'(cfg_pending[1]);
      ntick += t_arr[i];
      if (i == 2) begin
        cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_period = CNT_W'(8); cfg_high = CNT_W'(4);
      end else cfg_wr = 1'b0;
    end
    chk("t2_pending_set", p_arr[3], 1);
    chk("t2_pending_hold", p_arr[5], 1);
    chk("t2_pending_clear", p_arr[6], 0);
    chk("t2_tick_6", t_arr[6], 1);
    chk("t2_no_tick_12", t_arr[12], 0);
    chk("t2_tick_14", t_arr[14], 1);
    chk("t2_tick_22", t_arr[22], 1);
    chk("t2_tick_count", ntick, 4);
    en[1] = 1'b0;

    // ch2: P=0 H=0, then P=1 H=5
    wr_cfg(2, 0, 0);
    en[2] = 1'b1;
    ntick = 0; nhigh = 0;
    repeat (8) begin
      @(negedge clk); ntick += int'(tick[2]); nhigh += int'(clk_out[2]);
    end
    chk("t3_low_ticks", ntick, 4);
    chk("t3_low_high", nhigh, 0);
    en[2] = 1'b0;
    wr_cfg(2, 1, 5);
    en[2] = 1'b1;
    ntick = 0; nhigh = 0;
    repeat (8) begin
      @(negedge clk); ntick += int'(tick[2]); nhigh += int'(clk_out[2]);
    end
    chk("t3_high_ticks", ntick, 4);
    chk("t3_high_high", nhigh, 8);
    en[2] = 1'b0;

    // ch3: out-of-range write, then write-through at cnt=P-1
    wr_cfg(3, 5, 2);
    en[3] = 1'b1;
    @(negedge clk);
    wr_cfg(4, 3, 1);
    chk("t4_bad_ch_pending", int'(cfg_pending), 0);
    repeat (3) @(negedge clk);
    wr_cfg(3, 7, 1);
    chk("t4_wt_tick", int'(tick[3]), 1);
    chk("t4_wt_pending", int'(cfg_pending[3]), 0);
    ntick = 0; nhigh = int'(clk_out[3]);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk); ntick += int'(tick[3]); nhigh += int'(clk_out[3]);
    end
    @(negedge clk);
    chk("t4_wt_gap_ticks", ntick, 0);
    chk("t4_wt_high", nhigh, 1);
    chk("t4_wt_next_tick", int'(tick[3]), 1);
    en[3] = 1'b0;

    // ch0: en drop mid-high, restart, async reset with pending config
    wr_cfg(0, 10, 4);
    en[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_mid_high", int'(clk_out[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("t5_en_drop", int'(clk_out[0]), 0);
    en[0] = 1'b1;
    @(negedge clk);
    chk("t5_restart_tick", int'(tick[0]), 1);
    nhigh = int'(clk_out[0]);
    repeat (9) begin @(negedge clk); nhigh += int'(clk_out[0]); end
    chk("t5_restart_high", nhigh, 4);
    @(negedge clk);
    chk("t5_restart_period", int'(tick[0]), 1);
    wr_cfg(0, 6, 2);
    chk("t5_pending", int'(cfg_pending[0]), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_clk_out", int'(clk_out), 0);
    chk("t5_async_pending", int'(cfg_pending), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_post_reset_tick", int'(tick[0]), 1);
    ntick = 0; nhigh = int'(clk_out[0]);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk); ntick += int'(tick[0]); nhigh += int'(clk_out[0]);
    end
    @(negedge clk);
    chk("t5_rst_gap_ticks", ntick, 0);
    chk("t5_rst_high", nhigh, RST_H);
    chk("t5_rst_period_tick", int'(tick[0]), 1);
    en[0] = 1'b0;

    // all channels P=3,5,7,9 over 1000 cycles
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      wr_cfg(c, 3 + 2 * c, $urandom_range(0, 10));
      cnt4[c] = 0;
    end
    en = '1;
    repeat (1000) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) cnt4[c] += int'(tick[c]);
    end
    chk("t6_ticks_p3", cnt4[0], 334);
    chk("t6_ticks_p5", cnt4[1], 200);
    chk("t6_ticks_p7", cnt4[2], 143);
    chk("t6_ticks_p9", cnt4[3], 112);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cfg_wr     = ($urandom_range(0, 3) == 0);
      cfg_ch     = 4'($urandom_range(0, 5));
      cfg_period = CNT_W'($urandom_range(0, 12));
      cfg_high   = CNT_W'($urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    cfg_wr = 1'b0;
    en = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
